// File: rtl/fft_demux_pkg.sv
// Shared types, limits and the lane decode helper for the 1-to-N sample demux.
package fft_demux_pkg;

    // Lane selection source: external binary select or internal bin counter.
    typedef enum logic {
        FFT_MODE_EXT  = 1'b0,
        FFT_MODE_AUTO = 1'b1
    } fft_mode_e;

    localparam int FFT_MAX_CH   = 4096;
    localparam int FFT_MAX_PIPE = 3;

    // One-hot decode sized for the largest supported lane count; callers keep
    // the low num_ch bits. Indices at or above num_ch decode to all zero.
    function automatic logic [FFT_MAX_CH-1:0] onehot_decode(input int unsigned index,
                                                             input int unsigned num_ch);
        logic [FFT_MAX_CH-1:0] vec;
        vec = '0;
        if ((index < num_ch) && (index < FFT_MAX_CH)) begin
            vec[index[11:0]] = 1'b1;
        end
        return vec;
    endfunction

endpackage

// File: rtl/fft_demux_1xn_stream_if.sv
// Bundle of the sample input and the lane-strobe output of the demux.
//
// Valid semantics: a sample is taken in every cycle where data_i_valid is high;
// there is no ready, the demux never stalls. On the output side a lane owns
// data_o only in the cycle its data_o_valid bit is high; frame_done and sel_err
// are single-cycle pulses aligned with the output stage.
interface fft_demux_1xn_stream_if #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_CH     = 2048,
    parameter int SEL_WIDTH  = $clog2(NUM_CH)
);
    logic                  mode;
    logic                  frame_start;
    logic [SEL_WIDTH-1:0]  data_sel;
    logic                  data_i_valid;
    logic [DATA_WIDTH-1:0] data_i;
    logic [DATA_WIDTH-1:0] data_o;
    logic [NUM_CH-1:0]     data_o_valid;
    logic [SEL_WIDTH-1:0]  data_o_sel;
    logic                  frame_done;
    logic                  sel_err;

    // Stream source / lane consumer side.
    modport master (
        output mode, frame_start, data_sel, data_i_valid, data_i,
        input  data_o, data_o_valid, data_o_sel, frame_done, sel_err
    );

    // Demux side.
    modport slave (
        input  mode, frame_start, data_sel, data_i_valid, data_i,
        output data_o, data_o_valid, data_o_sel, frame_done, sel_err
    );
endinterface

// File: rtl/fft_demux_pipe.sv
// STAGES-deep register chain for {data, index, valid, frame_last, err}.
// The index field only advances alongside a valid sample, so the last stage
// holds the most recently emitted lane. The inputs of the last stage are
// exposed as a tap so the caller can decode into a register parallel to it.
module fft_demux_pipe #(
    parameter int DATA_WIDTH = 16,
    parameter int SEL_WIDTH  = 11,
    parameter int STAGES     = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [SEL_WIDTH-1:0]  in_index,
    input  logic                  in_valid,
    input  logic                  in_last,
    input  logic                  in_err,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [SEL_WIDTH-1:0]  out_index,
    output logic                  out_valid,
    output logic                  out_last,
    output logic                  out_err,
    output logic [SEL_WIDTH-1:0]  tap_index,
    output logic                  tap_valid
);

    logic [DATA_WIDTH-1:0] data_q  [STAGES];
    logic [SEL_WIDTH-1:0]  index_q [STAGES];
    logic [STAGES-1:0]     valid_q;
    logic [STAGES-1:0]     last_q;
    logic [STAGES-1:0]     err_q;

    // Shift every field one stage per cycle; reset empties the whole chain.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                data_q[i]  <= '0;
                index_q[i] <= '0;
            end
            valid_q <= '0;
            last_q  <= '0;
            err_q   <= '0;
        end else begin
            data_q[0]  <= in_data;
            index_q[0] <= in_valid ? in_index : index_q[0];
            valid_q[0] <= in_valid;
            last_q[0]  <= in_last;
            err_q[0]   <= in_err;
            for (int i = 1; i < STAGES; i++) begin
                data_q[i]  <= data_q[i-1];
                index_q[i] <= valid_q[i-1] ? index_q[i-1] : index_q[i];
                valid_q[i] <= valid_q[i-1];
                last_q[i]  <= last_q[i-1];
                err_q[i]   <= err_q[i-1];
            end
        end
    end

    assign out_data  = data_q[STAGES-1];
    assign out_index = index_q[STAGES-1];
    assign out_valid = valid_q[STAGES-1];
    assign out_last  = last_q[STAGES-1];
    assign out_err   = err_q[STAGES-1];

    generate
        if (STAGES > 1) begin : g_tap_chain
            assign tap_index = index_q[STAGES-2];
            assign tap_valid = valid_q[STAGES-2];
        end else begin : g_tap_input
            assign tap_index = in_index;
            assign tap_valid = in_valid;
        end
    endgenerate

endmodule

// File: rtl/fft_demux_1xn_stream.sv
// 1-to-NUM_CH sample demultiplexer: picks a lane per valid sample from an
// external select or an auto-incrementing bin counter, delays the sample by
// PIPE_STAGES cycles and strobes that lane's one-hot valid bit.
module fft_demux_1xn_stream
    import fft_demux_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int NUM_CH      = 2048,
    parameter int SEL_WIDTH   = $clog2(NUM_CH),
    parameter int PIPE_STAGES = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    fft_demux_1xn_stream_if.slave   bus
);

    localparam logic [SEL_WIDTH-1:0] LAST_IDX = SEL_WIDTH'(NUM_CH - 1);
    localparam logic [SEL_WIDTH-1:0] ONE      = SEL_WIDTH'(1);

    fft_mode_e             mode_e;
    logic [SEL_WIDTH-1:0]  cnt;
    logic [SEL_WIDTH-1:0]  cnt_next;
    logic [SEL_WIDTH-1:0]  idx;
    logic                  in_valid;
    logic                  in_last;
    logic                  in_err;

    logic [DATA_WIDTH-1:0] p_data;
    logic [SEL_WIDTH-1:0]  p_index;
    logic                  p_valid;
    logic                  p_last;
    logic                  p_err;
    logic [SEL_WIDTH-1:0]  tap_index;
    logic                  tap_valid;
    logic [NUM_CH-1:0]     lane_next;
    logic [NUM_CH-1:0]     lane_q;

    assign mode_e = fft_mode_e'(bus.mode);

    // Lane index, range check and next bin counter for the current input.
    always_comb begin
        idx      = '0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_err   = 1'b0;
        cnt_next = cnt;
        if (bus.data_i_valid) begin
            if (mode_e == FFT_MODE_AUTO) begin
                idx      = bus.frame_start ? '0 : cnt;
                in_valid = 1'b1;
                in_last  = (idx == LAST_IDX);
                cnt_next = in_last ? '0 : idx + ONE;
            end else begin
                // External samples leave the counter alone so auto mode resumes.
                idx = bus.data_sel;
                if (int'(bus.data_sel) >= NUM_CH) begin
                    in_err = 1'b1;
                end else begin
                    in_valid = 1'b1;
                end
            end
        end else if (bus.frame_start) begin
            cnt_next = '0;
        end
    end

    // Bin counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_next;
        end
    end

    fft_demux_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .SEL_WIDTH  (SEL_WIDTH),
        .STAGES     (PIPE_STAGES)
    ) u_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_data   (bus.data_i),
        .in_index  (idx),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_err    (in_err),
        .out_data  (p_data),
        .out_index (p_index),
        .out_valid (p_valid),
        .out_last  (p_last),
        .out_err   (p_err),
        .tap_index (tap_index),
        .tap_valid (tap_valid)
    );

    // Decode the index entering the last stage so the strobe bus is a flop.
    always_comb begin
        lane_next = '0;
        if (tap_valid) begin
            lane_next = NUM_CH'(onehot_decode(32'(tap_index), NUM_CH));
        end
    end

    // One-hot strobe register, clocked in step with the last pipeline stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            lane_q <= '0;
        end else begin
            lane_q <= lane_next;
        end
    end

    assign bus.data_o       = p_data;
    assign bus.data_o_valid = lane_q;
    assign bus.data_o_sel   = p_index;
    assign bus.frame_done   = p_valid & p_last;
    assign bus.sel_err      = p_err;

endmodule

// File: tb/tb_fft_demux_1xn_stream.sv
// Bench for fft_demux_1xn_stream: three instances (2048 lanes / 1 stage,
// 16 lanes / 2 stages, 12 lanes / 3 stages) driven by directed and random
// stimulus and checked every cycle against a per-sample lane model.
module tb_fft_demux_1xn_stream;
    import fft_demux_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ---------------- stimulus variables ----------------
    logic        in_mode  [3];
    logic        in_fs    [3];
    logic        in_valid [3];
    logic [11:0] in_sel   [3];
    logic [15:0] in_data  [3];

    fft_demux_1xn_stream_if #(.DATA_WIDTH(16), .NUM_CH(2048)) if_a ();
    fft_demux_1xn_stream_if #(.DATA_WIDTH(16), .NUM_CH(16))   if_b ();
    fft_demux_1xn_stream_if #(.DATA_WIDTH(16), .NUM_CH(12))   if_c ();

    assign if_a.mode = in_mode[0];  assign if_a.frame_start = in_fs[0];
    assign if_a.data_i_valid = in_valid[0];  assign if_a.data_sel = in_sel[0][10:0];
    assign if_a.data_i = in_data[0];
    assign if_b.mode = in_mode[1];  assign if_b.frame_start = in_fs[1];
    assign if_b.data_i_valid = in_valid[1];  assign if_b.data_sel = in_sel[1][3:0];
    assign if_b.data_i = in_data[1];
    assign if_c.mode = in_mode[2];  assign if_c.frame_start = in_fs[2];
    assign if_c.data_i_valid = in_valid[2];  assign if_c.data_sel = in_sel[2][3:0];
    assign if_c.data_i = in_data[2];

    fft_demux_1xn_stream #(.DATA_WIDTH(16), .NUM_CH(2048), .PIPE_STAGES(1))
        dut_a (.clk(clk), .rst(rst), .bus(if_a));
    fft_demux_1xn_stream #(.DATA_WIDTH(16), .NUM_CH(16), .PIPE_STAGES(2))
        dut_b (.clk(clk), .rst(rst), .bus(if_b));
    fft_demux_1xn_stream #(.DATA_WIDTH(16), .NUM_CH(12), .PIPE_STAGES(3))
        dut_c (.clk(clk), .rst(rst), .bus(if_c));

    function automatic int nch(input int i);
        case (i)
            0:       return 2048;
            1:       return 16;
            default: return 12;
        endcase
    endfunction

    function automatic int pst(input int i);
        return i + 1;
    endfunction

    // ---------------- reference model state ----------------
    // Expected output per instance per cycle, in an 8-entry ring indexed by
    // the clock edge after which it must be visible.
    // kind: 0 = nothing emitted, 1 = lane strobe, 2 = select error.
    int e_kind [3][8];
    int e_lane [3][8];
    int e_data [3][8];
    bit e_fd   [3][8];
    bit e_rst  [3][8];
    int mcnt     [3];
    int last_sel [3];
    int cyc = 0;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    // ---------------- scoreboard ----------------
    task automatic chk(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got == exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
        end
    endtask

    // Predict what the upcoming edge produces, from the lane rules alone.
    task automatic model_edge();
        int n, p, s, lane;
        for (int i = 0; i < 3; i++) begin
            n = nch(i);
            p = pst(i);
            if (rst) begin
                for (int k = 0; k < p; k++) begin
                    s = (cyc + k) % 8;
                    e_kind[i][s] = 0;
                    e_fd[i][s]   = 1'b0;
                    e_rst[i][s]  = (k == 0);
                end
                mcnt[i] = 0;
            end else begin
                s = (cyc + p - 1) % 8;
                e_kind[i][s] = 0;
                e_fd[i][s]   = 1'b0;
                e_rst[i][s]  = 1'b0;
                e_lane[i][s] = 0;
                e_data[i][s] = int'(in_data[i]);
                if (in_valid[i]) begin
                    if (in_mode[i] == FFT_MODE_EXT) begin
                        if (int'(in_sel[i]) >= n) begin
                            e_kind[i][s] = 2;
                        end else begin
                            e_kind[i][s] = 1;
                            e_lane[i][s] = int'(in_sel[i]);
                        end
                    end else begin
                        lane = in_fs[i] ? 0 : mcnt[i];
                        e_kind[i][s] = 1;
                        e_lane[i][s] = lane;
                        e_fd[i][s]   = (lane == n - 1);
                        mcnt[i]      = (lane + 1) % n;
                    end
                end else if (in_fs[i]) begin
                    mcnt[i] = 0;
                end
            end
        end
    endtask

    task automatic check_outputs();
        logic [2047:0] ov;
        logic [15:0]   od;
        int osel, ones, pos, s;
        bit ofd, oerr;
        for (int i = 0; i < 3; i++) begin
            s  = cyc % 8;
            ov = '0;
            case (i)
                0: begin
                    ov = if_a.data_o_valid; od = if_a.data_o; osel = int'(if_a.data_o_sel);
                    ofd = if_a.frame_done; oerr = if_a.sel_err;
                end
                1: begin
                    ov[15:0] = if_b.data_o_valid; od = if_b.data_o; osel = int'(if_b.data_o_sel);
                    ofd = if_b.frame_done; oerr = if_b.sel_err;
                end
                default: begin
                    ov[11:0] = if_c.data_o_valid; od = if_c.data_o; osel = int'(if_c.data_o_sel);
                    ofd = if_c.frame_done; oerr = if_c.sel_err;
                end
            endcase
            ones = $countones(ov);
            pos  = -1;
            for (int k = 0; k < 2048; k++) begin
                if (ov[k] && pos < 0) pos = k;
            end
            if (e_rst[i][s]) begin
                last_sel[i] = 0;
                chk($sformatf("rst_strobes_%0d", i), ones, 0);
                chk($sformatf("rst_data_%0d", i), od, 0);
                chk($sformatf("rst_sel_%0d", i), osel, 0);
                chk($sformatf("rst_fdone_%0d", i), ofd, 0);
                chk($sformatf("rst_selerr_%0d", i), oerr, 0);
            end else begin
                chk($sformatf("strobes_%0d", i), ones, (e_kind[i][s] == 1) ? 1 : 0);
                if (e_kind[i][s] == 1) begin
                    last_sel[i] = e_lane[i][s];
                    chk($sformatf("lane_%0d", i), pos, e_lane[i][s]);
                    chk($sformatf("data_%0d", i), od, e_data[i][s]);
                end
                chk($sformatf("sel_%0d", i), osel, last_sel[i]);
                chk($sformatf("fdone_%0d", i), ofd, e_fd[i][s]);
                chk($sformatf("selerr_%0d", i), oerr, (e_kind[i][s] == 2) ? 1 : 0);
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        check_outputs();
        cyc++;
    endtask

    task automatic idle_all();
        for (int i = 0; i < 3; i++) begin
            in_mode[i]  = 1'b0;
            in_fs[i]    = 1'b0;
            in_valid[i] = 1'b0;
            in_sel[i]   = '0;
            in_data[i]  = 16'($urandom_range(0, 65535));
        end
    endtask

    task automatic one(input int i, input bit v, input bit m, input bit fs,
                       input int sel, input int data);
        idle_all();
        in_valid[i] = v;
        in_mode[i]  = m;
        in_fs[i]    = fs;
        in_sel[i]   = 12'(sel);
        in_data[i]  = 16'(data);
        tick();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit rmode [3];
        for (int i = 0; i < 3; i++) begin
            mcnt[i] = 0; last_sel[i] = 0;
            for (int s = 0; s < 8; s++) begin
                e_kind[i][s] = 0; e_lane[i][s] = 0; e_data[i][s] = 0;
                e_fd[i][s] = 1'b0; e_rst[i][s] = 1'b0;
            end
        end

        // Reset held for three cycles with valid samples on every input.
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            idle_all();
            for (int i = 0; i < 3; i++) begin
                in_valid[i] = 1'b1; in_mode[i] = 1'b1;
            end
            tick();
        end
        rst = 1'b0;
        // Auto samples straight after reset start at lane 0.
        for (int k = 0; k < 3; k++) one(1, 1, 1, 0, 0, $urandom_range(0, 65535));

        // External select on the 2048-lane instance.
        one(0, 1, 0, 0, 0,    16'hA000);
        one(0, 1, 0, 0, 1,    16'hA001);
        one(0, 1, 0, 0, 1023, 16'hA000 + 1023);
        one(0, 1, 0, 0, 2047, 16'hA000 + 2047);
        one(0, 0, 0, 0, 0, 0);

        // Full auto frame on 16 lanes, then a 17th sample wrapping to lane 0.
        one(1, 1, 1, 1, 0, $urandom_range(0, 65535));
        for (int k = 0; k < 16; k++) one(1, 1, 1, 0, 0, $urandom_range(0, 65535));
        // Gaps in valid: no strobes and no counter advance.
        for (int k = 0; k < 8; k++) one(1, k % 2, 1, 0, 0, $urandom_range(0, 65535));

        // frame_start mid-frame restarts at lane 0 without a frame_done.
        one(1, 1, 1, 1, 0, $urandom_range(0, 65535));
        for (int k = 0; k < 4; k++) one(1, 1, 1, 0, 0, $urandom_range(0, 65535));
        one(1, 1, 1, 1, 0, $urandom_range(0, 65535));
        one(1, 1, 1, 0, 0, $urandom_range(0, 65535));
        // frame_start with the lane-15 sample overrides it.
        for (int k = 0; k < 13; k++) one(1, 1, 1, 0, 0, $urandom_range(0, 65535));
        one(1, 1, 1, 1, 0, $urandom_range(0, 65535));
        // frame_start without a sample reloads the counter.
        one(1, 0, 1, 1, 0, 0);
        one(1, 1, 1, 0, 0, $urandom_range(0, 65535));

        // Mode interleave: lanes 0, 1, 2, 9, 3.
        one(1, 1, 1, 1, 0, $urandom_range(0, 65535));
        one(1, 1, 1, 0, 0, $urandom_range(0, 65535));
        one(1, 1, 1, 0, 0, $urandom_range(0, 65535));
        one(1, 1, 0, 0, 9, $urandom_range(0, 65535));
        one(1, 1, 1, 0, 0, $urandom_range(0, 65535));

        // Out-of-range selects on the 12-lane instance.
        one(2, 1, 0, 0, 13, $urandom_range(0, 65535));
        one(2, 1, 0, 0, 11, $urandom_range(0, 65535));
        one(2, 1, 0, 0, 12, $urandom_range(0, 65535));
        one(2, 1, 0, 0, 15, $urandom_range(0, 65535));
        one(2, 1, 1, 1, 0, $urandom_range(0, 65535));
        for (int k = 0; k < 12; k++) one(2, 1, 1, 0, 0, $urandom_range(0, 65535));

        // Reset held mid-frame drops the in-flight samples.
        for (int k = 0; k < 5; k++) one(1, 1, 1, 0, 0, $urandom_range(0, 65535));
        rst = 1'b1;
        one(1, 1, 1, 0, 0, $urandom_range(0, 65535));
        one(1, 1, 1, 0, 0, $urandom_range(0, 65535));
        rst = 1'b0;
        for (int k = 0; k < 4; k++) one(1, 1, 1, 0, 0, $urandom_range(0, 65535));

        // Random traffic on all three instances with sticky modes.
        for (int i = 0; i < 3; i++) rmode[i] = 1'b1;
        for (int k = 0; k < 500; k++) begin
            rst = (k >= 250 && k < 252);
            for (int i = 0; i < 3; i++) begin
                if ($urandom_range(0, 9) == 0) rmode[i] = ~rmode[i];
                in_mode[i]  = rmode[i];
                in_valid[i] = ($urandom_range(0, 3) != 0);
                in_sel[i]   = 12'($urandom_range(0, (i == 0) ? 2047 : 15));
                in_data[i]  = 16'($urandom_range(0, 65535));
                in_fs[i]    = (rmode[i] || !in_valid[i]) && ($urandom_range(0, 19) == 0);
            end
            tick();
        end
        rst = 1'b0;

        // Drain the deepest pipeline.
        for (int k = 0; k < 4; k++) one(0, 0, 0, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/fft_demux_1xn_stream.md
Name: fft_demux_1xn_stream

Overview:
- Parametrised 1-to-NUM_CH sample demultiplexer for the FFT datapath. It steers a single input stream onto a one-hot lane-valid bus feeding per-bin buffers, for example 2048 bins.
- Channel selection comes either from an external binary select or from an internal auto-incrementing bin counter.
- Adds input-valid gating, frame tracking, configurable pipeline latency and out-of-range select detection.

Parameters:
- DATA_WIDTH, 16, sample width in bits.
- NUM_CH, 2048, number of output lanes; any value 2..4096, power of two not required.
- SEL_WIDTH, $clog2(NUM_CH), width of the select and counter fields.
- PIPE_STAGES, 1, register stages from input to output; legal range 1..3.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- mode  input  1  0 = external select (data_sel), 1 = auto-sequential counter; sampled with each valid input.
- frame_start  input  1  restarts the auto counter; the sample accepted in the same cycle goes to lane 0.
- data_sel  input  SEL_WIDTH  binary lane index, used when mode=0.
- data_i_valid  input  1  input sample valid.
- data_i  input  DATA_WIDTH  input sample.
- data_o  output  DATA_WIDTH  delayed sample, common to all lanes.
- data_o_valid  output  NUM_CH  one-hot lane strobe; all zero when no sample is emitted.
- data_o_sel  output  SEL_WIDTH  binary index of the lane strobed this cycle.
- frame_done  output  1  pulse coincident with the output of lane NUM_CH-1 in auto mode.
- sel_err  output  1  pulse when a valid sample arrives in mode=0 with data_sel >= NUM_CH.

Behaviour:
- Reset, synchronous and active-high:
  - data_o, data_o_valid, data_o_sel, frame_done and sel_err are all 0.
  - The auto counter is 0.
  - All pipeline stages are cleared, so in-flight samples are discarded. Reset held mid-frame drops the rest of the frame.
- Latency: an input accepted at cycle t appears on the outputs at cycle t+PIPE_STAGES. There is no backpressure; every cycle can accept a sample.
- Lane index computation, one per valid input:
  - mode=0: index = data_sel.
  - mode=1: index = 0 if frame_start is high, otherwise index = the counter value.
- Auto counter:
  - Advances only on valid inputs in mode=1.
  - Next value = index+1, wrapping from NUM_CH-1 to 0.
  - frame_start without data_i_valid loads the counter with 0.
  - Valid inputs in mode=0 leave the counter unchanged, so switching back to mode=1 resumes where it stopped.
- Output strobes:
  - data_o_valid[index] is asserted for exactly one cycle per accepted in-range sample.
  - data_o_valid is all zero when data_i_valid was low, and when the sample was out of range.
- Data path: data_o carries the pipelined data_i in every cycle. data_o is meaningful only while data_o_valid is non-zero.
- data_o_sel carries the pipelined index and holds its last value when no sample is emitted.
- frame_done asserts only in mode=1, when the emitted index = NUM_CH-1, aligned with that strobe.
- sel_err (mode=0, data_sel >= NUM_CH; only reachable when NUM_CH is not a power of two):
  - No lane strobes and the sample is dropped.
  - sel_err pulses at the output stage, with the same latency as a strobe would have.
- Boundary cases:
  - Wrap: in mode=1, frame_start coincident with the lane NUM_CH-1 sample overrides it. That sample goes to lane 0 and frame_done stays low.
  - Mode changes between samples are legal and take effect on the next valid input.
- Decode is combinational, one-hot from the index, before the last pipeline register. The output must be registered (no combinational input-to-output path).

Decomposition:
- Package fft_demux_pkg holds:
  - typedef fft_mode_e {FFT_MODE_EXT=0, FFT_MODE_AUTO=1};
  - localparam limits FFT_MAX_CH=4096 and FFT_MAX_PIPE=3;
  - a parametrised function onehot_decode(index, num_ch).
- Sub-module fft_demux_pipe: generic PIPE_STAGES-deep register chain with synchronous reset. It carries {data, index, valid, frame_last, err} and is instantiated once.
- Top level keeps the counter, index mux, range check and final one-hot decode.

Test Plan:
- Reset: assert rst for 3 cycles with data_i_valid=1 -> all outputs 0 during and 1 cycle after reset; counter restarts at lane 0.
- External mode, NUM_CH=2048, PIPE_STAGES=1: data_sel=0, 1, 1023, 2047 with data_i=16'hA000+sel -> data_o_valid bit sel high for one cycle at t+1, data_o matches, data_o_sel=sel.
- Auto mode, NUM_CH=16, PIPE_STAGES=2:
  - frame_start, then 16 consecutive valid samples -> lanes 0..15 strobed in order starting 2 cycles after the frame_start sample, and frame_done high with lane 15.
  - A 17th sample -> goes to lane 0.
  - Gaps in data_i_valid -> no strobes in the gap cycles and no counter advance.
- frame_start mid-frame: NUM_CH=16, after 5 samples assert frame_start with a valid sample -> that sample goes to lane 0, the next to lane 1, and frame_done does not pulse.
- Out of range: NUM_CH=12, mode=0, data_sel=13 valid -> data_o_valid=0 and sel_err=1 for one cycle at t+PIPE_STAGES. data_sel=11 -> lane 11 strobed and sel_err=0.
- Mode interleave: NUM_CH=16, auto for 3 samples (lanes 0-2), one ext sample with data_sel=9, then auto again -> lanes 0, 1, 2, 9, 3.
